// File: rtl/div_unit_pkg.sv
// Shared definitions for the divide unit: FSM state encodings, iteration count
// and the controller StallBus width.
`timescale 1ns/1ps
package div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_e;

  localparam int DIV_ITERS   = 32;
  localparam int DIV_CNT_W   = $clog2(DIV_ITERS);
  localparam int STALL_BUS_W = 5;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle 32-bit signed/unsigned divider: radix-2 restoring, one quotient
// bit per cycle, stalls the EX stage while busy.
`timescale 1ns/1ps
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        div_valid,
  input  logic        div_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        result_ready,
  output logic        stall_for_ex
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_ITERS - 1);

  div_state_e           state;
  div_state_e           state_next;
  logic [DIV_CNT_W-1:0] count;
  logic [64:0]          acc;
  logic [31:0]          divisor_abs;
  logic                 quot_neg;
  logic                 rem_neg;

  logic        accept;
  logic [31:0] dividend_in_abs;
  logic [31:0] divisor_in_abs;
  logic [64:0] shifted;
  logic [32:0] diff;
  logic [64:0] acc_step;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic        unused_acc_msb;

  assign accept = (state == IDLE) && div_valid && !flush;

  assign dividend_in_abs = (div_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
  assign divisor_in_abs  = (div_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;

  // Restoring step: shift in, trial-subtract, keep the difference if it did not borrow
  assign shifted  = acc << 1;
  assign diff     = shifted[64:32] - {1'b0, divisor_abs};
  assign acc_step = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};

  assign quot_fix       = quot_neg ? (32'd0 - acc_step[31:0])  : acc_step[31:0];
  assign rem_fix        = rem_neg  ? (32'd0 - acc_step[63:32]) : acc_step[63:32];
  assign unused_acc_msb = acc_step[64];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      divisor_abs <= '0;
      quot_neg    <= 1'b0;
      rem_neg     <= 1'b0;
      result_lo   <= '0;
      result_hi   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc         <= {33'd0, dividend_in_abs};
        divisor_abs <= divisor_in_abs;
        count       <= '0;
        quot_neg    <= div_signed && (dividend[31] ^ divisor[31]);
        rem_neg     <= div_signed && dividend[31];
      end else if (state == ON && !flush) begin
        acc   <= acc_step;
        count <= count + 1'b1;
        if (count == LAST_STEP) begin
          result_lo <= quot_fix;
          result_hi <= rem_fix;
        end
      end else if (state == DIVZERO && !flush) begin
        result_lo <= '0;
        result_hi <= '0;
      end
    end
  end

  always_comb begin
    state_next   = state;
    result_ready = 1'b0;
    stall_for_ex = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          stall_for_ex = div_valid;
          if (div_valid) state_next = (divisor == 32'd0) ? DIVZERO : ON;
        end
        ON: begin
          stall_for_ex = 1'b1;
          if (count == LAST_STEP) state_next = END;
        end
        DIVZERO: begin
          stall_for_ex = 1'b1;
          state_next   = END;
        end
        END: begin
          result_ready = 1'b1;
          state_next   = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-002 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port flush, input, 1 bit: annul the in-flight divide (driven by the pipeline controller).
REQ-004 SHALL have port div_valid, input, 1 bit: the EX-stage instruction is DIV or DIVU.
REQ-005 SHALL have port div_signed, input, 1 bit: 1 = DIV (two's complement), 0 = DIVU.
REQ-006 SHALL have port dividend, input, 32 bits: rs operand.
REQ-007 SHALL have port divisor, input, 32 bits: rt operand.
REQ-008 SHALL have port result_lo, output, 32 bits: quotient, destined for LO.
REQ-009 SHALL have port result_hi, output, 32 bits: remainder, destined for HI.
REQ-010 SHALL have port result_ready, output, 1 bit: result_lo and result_hi are valid this cycle.
REQ-011 SHALL have port stall_for_ex, output, 1 bit: stall request to the pipeline controller.

Function
REQ-012 SHALL implement the FSM states IDLE, DIVZERO, ON and END.
REQ-013 IDLE: when div_valid=1 and flush=0, SHALL latch the operands and go to DIVZERO if divisor==0, otherwise go to ON with the iteration counter cleared.
REQ-014 Signed mode: SHALL latch |dividend| and |divisor|, and record quotient sign = sign(dividend) XOR sign(divisor) and remainder sign = sign(dividend).
REQ-015 ON: SHALL perform one radix-2 restoring step per cycle on a 65-bit shift/subtract register for exactly 32 cycles, then go to END.
REQ-016 At the ON-to-END transition, SHALL sign-correct the quotient and remainder by two's-complement negation where the recorded sign is 1.
REQ-017 DIVZERO: SHALL go to END after 1 cycle with result_lo = result_hi = 0.
REQ-018 END: SHALL drive result_ready=1 for exactly 1 cycle and then return to IDLE unconditionally; div_valid still high in the END cycle SHALL NOT start a new divide.
REQ-019 stall_for_ex SHALL be combinational and equal (IDLE & div_valid & ~flush) | ON | DIVZERO; it SHALL be 0 in END.
REQ-020 Latency for a nonzero divisor: accept at cycle t0, result_ready at t33, stall_for_ex high t0..t32 (33 cycles).
REQ-021 Latency for a zero divisor: result_ready at t2, stall_for_ex high t0..t1.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge, hold result_ready=0, and drive stall_for_ex=0 in the flush cycle.
REQ-023 Signed 0x8000_0000 / 0xFFFF_FFFF SHALL wrap to quotient 0x8000_0000, remainder 0.
REQ-024 result_lo and result_hi SHALL hold their last value outside END; they SHALL be consumed only when result_ready=1.

Reset
REQ-025 resetn=0 SHALL immediately, without waiting for clk, force state IDLE and clear the counter, result_lo, result_hi and result_ready; stall_for_ex SHALL then be 0 unless IDLE accept conditions hold, including reset mid-divide.
REQ-026 After resetn deasserts, the first accept SHALL occur no earlier than the first rising clk edge.

Structure
REQ-027 State encodings (2 bits) and the iteration count constant (32) SHALL live in the shared defines header beside the StallBus width.
REQ-028 SHALL be a single module with no sub-module; stall_for_ex SHALL connect directly to the controller input of the same name.

Verification
REQ-029 Unsigned 100/7 accepted at t0 SHALL give result_lo=14 and result_hi=2 with result_ready=1 at t33, stall_for_ex high t0..t32.
REQ-030 Signed -7/2 (0xFFFF_FFF9 / 2) SHALL give result_lo=0xFFFF_FFFD and result_hi=0xFFFF_FFFF.
REQ-031 5/0 SHALL give result_ready at t2 with result_lo=result_hi=0, stall_for_ex high t0..t1.
REQ-032 Signed 0x8000_0000 / 0xFFFF_FFFF SHALL give result_lo=0x8000_0000 and result_hi=0; unsigned 0xFFFF_FFFF/1 SHALL give result_lo=0xFFFF_FFFF and result_hi=0.
REQ-033 flush pulse at t10 of a divide SHALL give stall_for_ex=0 at t10 and IDLE at t11, with result_ready never asserted; a new divide accepted at t12 SHALL complete at t45.
REQ-034 resetn low at t15 mid-divide SHALL immediately clear all outputs; after release, 9/3 SHALL give result_lo=3 and result_hi=0.
